// File: rtl/load_unit.sv
// Memory-load extraction unit: word-aligned read, byte/halfword select, sign/zero extension.
// Optional alignment checking is enabled by defining LOAD_ALIGN_CHECK_EN.
module load_unit #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  control,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [31:0] data_out,
    output logic        done,
    output logic        busy,
    output logic        misaligned
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        sign_q, sign_d;
    logic        mem_read_q, mem_read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] data_q, data_d;
    logic        mis_q, mis_d;
    logic        misalign_req;

`ifdef LOAD_ALIGN_CHECK_EN
    assign misalign_req = ((control == 2'b10) && addr[0]) ||
                          ((control == 2'b11) && (addr[1:0] != 2'b00));
`else
    assign misalign_req = 1'b0;
`endif

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b01:   r = {{24{sgn & b[7]}}, b};
            2'b10:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ctrl_d     = ctrl_q;
        sign_d     = sign_q;
        mem_read_d = mem_read_q;
        busy_d     = busy_q;
        data_d     = data_q;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (control != 2'b00)) begin
                    if (misalign_req) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d     = addr;
                        ctrl_d     = control;
                        sign_d     = sign;
                        mem_read_d = 1'b1;
                        busy_d     = 1'b1;
                        cnt_d      = CNT_INIT;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d     = extract(mem_rdata, addr_q[1:0], ctrl_q, sign_q);
                    done_d     = 1'b1;
                    mem_read_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'd0;
            ctrl_q     <= 2'b00;
            sign_q     <= 1'b0;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ctrl_q     <= ctrl_d;
            sign_q     <= sign_d;
            mem_read_q <= mem_read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_q     <= data_d;
            mis_q      <= mis_d;
        end
    end

    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_read   = mem_read_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard testbench for load_unit: directed loads, reset abort, then randomized loads.
// Expected results come from an arithmetic model of the load rules and a bench-side memory.
module tb_load_unit;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  control;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [31:0] data_out;
    logic        done;
    logic        busy;
    logic        misaligned;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_accepted = 0;
    int          n_done   = 0;
    int          rd_age   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_data = 32'd0;
    logic [31:0] mem[logic [31:0]];

    load_unit #(.MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .control(control), .sign(sign),
        .addr(addr), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_read(mem_read),
        .data_out(data_out), .done(done), .busy(busy), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model: the word is only valid in the cycle before the sampling edge.
    always @(posedge clock) rd_age <= mem_read ? rd_age + 1 : 0;
    always @(rd_age, mem_read, mem_addr)
        mem_rdata = (mem_read && rd_age == LAT - 1) ? mem_word(mem_addr) : 32'hDEAD_BEEF;

    function automatic bit is_aligned(input logic [31:0] a, input logic [1:0] c);
`ifdef LOAD_ALIGN_CHECK_EN
        return !((c == 2'b10 && a[0]) || (c == 2'b11 && a[1:0] != 2'b00));
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] c, input logic s);
        int unsigned     bits, shift;
        longint unsigned v;
        case (c)
            2'b01:   begin bits = 8;  shift = 8 * int'(a[1:0]); end
            2'b10:   begin bits = 16; shift = 16 * int'(a[1]);  end
            default: begin bits = 32; shift = 0;                end
        endcase
        v = (longint'(word) >> shift) & ((64'd1 << bits) - 1);
        if (s && bits < 32 && v >= (64'd1 << (bits - 1)))
            v = v + (64'h1_0000_0000 - (64'd1 << bits));
        return v[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                checkOutput("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [1:0] c, input logic s,
                                 input bit poke_busy);
        logic [31:0] word_addr;
        bit          accepted;
        word_addr = {a[31:2], 2'b00};
        accepted  = (c != 2'b00) && is_aligned(a, c);
        @(negedge clock);
        start = 1'b1; control = c; sign = s; addr = a;
        @(posedge clock); #1;
        start = 1'b0;
        if (c == 2'b00) begin
            checkOutput("noop_busy", {31'd0, busy}, 32'd0);
            checkOutput("noop_read", {31'd0, mem_read}, 32'd0);
            return;
        end
        if (!accepted) begin
            checkOutput("mis_pulse", {31'd0, misaligned}, 32'd1);
            checkOutput("mis_no_read", {31'd0, mem_read}, 32'd0);
            checkOutput("mis_busy", {31'd0, busy}, 32'd0);
            checkOutput("mis_data_hold", data_out, last_data);
            @(posedge clock); #1;
            checkOutput("mis_one_cycle", {31'd0, misaligned}, 32'd0);
            checkOutput("mis_still_idle", {31'd0, mem_read}, 32'd0);
            return;
        end
        last_data = ref_load(mem_word(word_addr), a, c, s);
        exp_q.push_back(last_data);
        n_accepted++;
        for (int k = 0; k < LAT; k++) begin
            checkOutput("busy_high", {31'd0, busy}, 32'd1);
            checkOutput("mem_read_high", {31'd0, mem_read}, 32'd1);
            checkOutput("mem_addr", mem_addr, word_addr);
            checkOutput("done_early", {31'd0, done}, 32'd0);
            checkOutput("no_misaligned", {31'd0, misaligned}, 32'd0);
            if (poke_busy && k == 0) begin
                start = 1'b1; control = 2'b11; addr = a ^ 32'h0000_0040;
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        checkOutput("done_pulse", {31'd0, done}, 32'd1);
        checkOutput("busy_low", {31'd0, busy}, 32'd0);
        checkOutput("mem_read_low", {31'd0, mem_read}, 32'd0);
        checkOutput("mem_addr_hold", mem_addr, word_addr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] waddr;
        mem[32'h100] = 32'h80FF_7F01;
        start = 1'b0; control = 2'b00; sign = 1'b0; addr = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_data_out", data_out, 32'd0);
        checkOutput("rst_flags", {28'd0, mem_read, done, busy, misaligned}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] directed loads");
        applyStimulus(32'h103, 2'b01, 1'b1, 1'b0);
        applyStimulus(32'h101, 2'b01, 1'b0, 1'b0);
        applyStimulus(32'h102, 2'b10, 1'b1, 1'b0);
        applyStimulus(32'h100, 2'b10, 1'b0, 1'b0);
        applyStimulus(32'h100, 2'b11, 1'b1, 1'b1);
        applyStimulus(32'h100, 2'b00, 1'b1, 1'b0);
        applyStimulus(32'h101, 2'b10, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("lh_0x101_result", data_out, last_data);

        $display("[TB] reset during WAIT");
        @(negedge clock);
        start = 1'b1; control = 2'b11; sign = 1'b0; addr = 32'h100;
        @(posedge clock); #1;
        start = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("abort_mem_addr", mem_addr, 32'd0);
        checkOutput("abort_data_out", data_out, 32'd0);
        checkOutput("abort_flags", {28'd0, mem_read, done, busy, misaligned}, 32'd0);
        last_data = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clock); #1;
            checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        end
        applyStimulus(32'h100, 2'b01, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("post_reset_lb", data_out, 32'h0000_0001);

        $display("[TB] randomized loads");
        for (int i = 0; i < 4; i++) begin
            waddr = {$urandom_range(32'h40, 32'h7F), 2'b00} << 4;
            mem[waddr] = $urandom;
        end
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       waddr = 32'h100;
                1:       waddr = {$urandom_range(32'h40, 32'h7F), 2'b00} << 4;
                default: waddr = {$urandom, 2'b00};
            endcase
            applyStimulus(waddr | 32'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        repeat (LAT + 3) @(posedge clock);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("done_count", 32'(n_done), 32'(n_accepted));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
